id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register plus load-use hazard detection. Feeds the forwarding unit
//  (ID_EXrs/ID_EXrt) and the EX stage. Inserts one bubble on load-use, kills on flush,
//  holds on external stall, and keeps a saturating bubble counter for perf.
// PARAMETERS
//  DATA_W   32  register-file operand / immediate width
//  REG_AW   5   register address width
//  ALUOP_W  2   ALUOp field width
//  CNT_W    16  bubble counter width
// PORTS
//  clk           in   1        rising-edge clock
//  rst_n         in   1        async active-low reset
//  stall_in      in   1        downstream (MEM) stall; hold ID/EX contents
//  flush         in   1        branch/jump resolved taken; kill instruction entering EX
//  IF_IDrs       in   REG_AW   decoded rs
//  IF_IDrt       in   REG_AW   decoded rt
//  IF_IDrd       in   REG_AW   decoded rd
//  id_uses_rt    in   1        instruction reads rt as a source
//  id_valid      in   1        IF/ID holds a real instruction
//  id_rdata1     in   DATA_W   RF read port 1
//  id_rdata2     in   DATA_W   RF read port 2
//  id_imm        in   DATA_W   sign-extended immediate
//  id_ctrl       in   6+ALUOP_W {RegWrite,MemRead,MemWrite,MemtoReg,ALUSrc,RegDst,ALUOp}
//  pc_write      out  1        0 = freeze PC this cycle
//  if_id_write   out  1        0 = freeze IF/ID this cycle
//  ID_EXrs       out  REG_AW   registered rs (to forwarding unit)
//  ID_EXrt       out  REG_AW   registered rt (to forwarding unit)
//  ID_EXwr       out  REG_AW   registered dest = RegDst ? rd : rt
//  ID_EXdata1    out  DATA_W   registered operand 1
//  ID_EXdata2    out  DATA_W   registered operand 2
//  ID_EXimm      out  DATA_W   registered immediate
//  ID_EXctrl     out  6+ALUOP_W registered control bundle
//  ID_EXvalid    out  1        EX slot holds a real instruction
//  bubble_cnt    out  CNT_W    bubbles inserted since reset, saturating
// BEHAVIOUR
//  Reset: all ID_EX* outputs 0, bubble_cnt 0, FSM RUN. Outputs are valid 1 cycle after the ID inputs are sampled.
//  Hazard (combinational): lu = ID_EXctrl.MemRead & ID_EXvalid & ID_EXrt!=0 & id_valid
//    & (ID_EXrt==IF_IDrs | (id_uses_rt & ID_EXrt==IF_IDrt)).
//  pc_write = if_id_write = ~(stall_in | (lu & ~flush)).
//  Per-edge update priority (stall_in sampled before flush; flush producer holds flush
//  until stall_in drops):
//   1 stall_in=1: every ID_EX* register holds; no count.
//   2 flush=1: load bubble (ctrl=0, valid=0, data/addr fields=0); not counted.
//   3 lu=1: load bubble; bubble_cnt+1 (saturates at all-ones); FSM RUN->BUBBLE.
//   4 else: load ID inputs; valid=id_valid; ctrl forced 0 when id_valid=0.
//  FSM RUN/BUBBLE: BUBBLE lasts exactly one edge unless stall_in holds it. Exit to RUN on the next
//   non-stalled edge. A second lu seen while in BUBBLE is a design error (assertion), because
//   the bubble clears MemRead.
//  ID_EXwr is computed at load time from id_ctrl.RegDst; it is 0 for bubbles, so the forwarder's !=0 guard suppresses them.
//  Reset mid-stall: immediate clear; pc_write/if_id_write return to 1 while rst_n is low.
// STRUCTURE
//  Shared package: ctrl bundle field offsets (CTRL_REGWRITE...CTRL_ALUOP), CTRL_W=6+ALUOP_W,
//   BUBBLE_CTRL constant.
//  One sub-module: hazard_detect (pure combinational lu/pc_write/if_id_write). Register, FSM
//   and counter stay in id_ex_stage.
// TESTING
//  lw $2 in EX, IF_IDrs=2 -> pc_write=0, if_id_write=0; next cycle ID_EXctrl=0, valid=0, bubble_cnt=1.
//  lw $2 in EX, IF_IDrt=2, id_uses_rt=0 -> no stall; instruction loads normally.
//  lw $0 in EX, IF_IDrs=0 -> no stall (zero register).
//  lu and flush on the same edge -> bubble loaded, bubble_cnt unchanged, pc_write=1.
//  stall_in=1 for 3 cycles with add in ID/EX -> ID_EX* stable, pc_write=0; resumes on release.
//  Force bubble_cnt=16'hFFFF, then trigger lu -> count stays 16'hFFFF; rst_n low mid-stall -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline stage.
// The control bundle is {RegWrite,MemRead,MemWrite,MemtoReg,ALUSrc,RegDst,ALUOp}.
// ALUOp occupies the low ALUOP_W bits.
// Each single-bit flag sits at bit position ALUOP_W + CTRL_<flag>.
// This keeps the offsets valid when a different ALUOp width is chosen.
package id_ex_stage_pkg;

  localparam int DEF_ALUOP_W = 2;
  localparam int CTRL_W      = 6 + DEF_ALUOP_W;

  // ALUOp base and flag offsets above the ALUOp field
  localparam int CTRL_ALUOP    = 0;
  localparam int CTRL_REGDST   = 0;
  localparam int CTRL_ALUSRC   = 1;
  localparam int CTRL_MEMTOREG = 2;
  localparam int CTRL_MEMWRITE = 3;
  localparam int CTRL_MEMREAD  = 4;
  localparam int CTRL_REGWRITE = 5;

  // A bubble carries no side effects: every control bit cleared
  localparam logic [CTRL_W-1:0] BUBBLE_CTRL = '0;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_BUBBLE = 1'b1
  } stage_state_e;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection for the ID/EX stage (purely combinational).
// Ports:
//   rst_n          async active-low reset; forces the write enables high while low
//   stall_in       downstream stall
//   flush          taken branch/jump; a flush overrides a load-use freeze
//   ex_memread     MemRead bit of the instruction currently in ID/EX
//   ex_valid       ID/EX holds a real instruction
//   ex_rt          destination of the load in ID/EX
//   if_id_rs       source register rs of the instruction in IF/ID
//   if_id_rt       source register rt of the instruction in IF/ID
//   id_uses_rt     the IF/ID instruction really reads rt
//   id_valid       IF/ID holds a real instruction
//   lu             load-use hazard detected
//   pc_write       0 = freeze the PC this cycle
//   if_id_write    0 = freeze IF/ID this cycle
module hazard_detect #(
  parameter int REG_AW = 5
) (
  input  logic              rst_n,
  input  logic              stall_in,
  input  logic              flush,
  input  logic              ex_memread,
  input  logic              ex_valid,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] if_id_rs,
  input  logic [REG_AW-1:0] if_id_rt,
  input  logic              id_uses_rt,
  input  logic              id_valid,
  output logic              lu,
  output logic              pc_write,
  output logic              if_id_write
);

  // A load writing $0 never creates a dependency, so it is excluded.
  // rt only matters when the consumer actually reads it.
  always_comb begin
    lu = ex_memread && ex_valid && (ex_rt != '0) && id_valid &&
         ((ex_rt == if_id_rs) || (id_uses_rt && (ex_rt == if_id_rt)));
    pc_write    = !rst_n || !(stall_in || (lu && !flush));
    if_id_write = pc_write;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion.
// A downstream stall holds the register.
// A flush loads a bubble.
// A load-use hazard loads a bubble and freezes PC and IF/ID for one cycle.
// bubble_cnt counts inserted load-use bubbles and saturates at all-ones.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   stall_in, flush               downstream stall, taken-branch kill
//   IF_IDrs/rt/rd, id_uses_rt     decoded register fields of the IF/ID instruction
//   id_valid                      IF/ID holds a real instruction
//   id_rdata1/2, id_imm, id_ctrl  operands, immediate, control bundle
//   pc_write, if_id_write         freeze controls for the front end
//   ID_EX*                        registered fields feeding EX and forwarding
//   bubble_cnt                    saturating load-use bubble count
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = DEF_ALUOP_W,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall_in,
  input  logic                 flush,
  input  logic [REG_AW-1:0]    IF_IDrs,
  input  logic [REG_AW-1:0]    IF_IDrt,
  input  logic [REG_AW-1:0]    IF_IDrd,
  input  logic                 id_uses_rt,
  input  logic                 id_valid,
  input  logic [DATA_W-1:0]    id_rdata1,
  input  logic [DATA_W-1:0]    id_rdata2,
  input  logic [DATA_W-1:0]    id_imm,
  input  logic [6+ALUOP_W-1:0] id_ctrl,
  output logic                 pc_write,
  output logic                 if_id_write,
  output logic [REG_AW-1:0]    ID_EXrs,
  output logic [REG_AW-1:0]    ID_EXrt,
  output logic [REG_AW-1:0]    ID_EXwr,
  output logic [DATA_W-1:0]    ID_EXdata1,
  output logic [DATA_W-1:0]    ID_EXdata2,
  output logic [DATA_W-1:0]    ID_EXimm,
  output logic [6+ALUOP_W-1:0] ID_EXctrl,
  output logic                 ID_EXvalid,
  output logic [CNT_W-1:0]     bubble_cnt
);

  localparam int CW          = 6 + ALUOP_W;
  localparam int MEMREAD_BIT = ALUOP_W + CTRL_MEMREAD;
  localparam int REGDST_BIT  = ALUOP_W + CTRL_REGDST;

  logic [REG_AW-1:0] rs_q, rs_d, rt_q, rt_d, wr_q, wr_d;
  logic [DATA_W-1:0] data1_q, data1_d, data2_q, data2_d, imm_q, imm_d;
  logic [CW-1:0]     ctrl_q, ctrl_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  stage_state_e      state_q, state_d;
  logic              lu;

  hazard_detect #(.REG_AW(REG_AW)) u_hazard (
    .rst_n       (rst_n),
    .stall_in    (stall_in),
    .flush       (flush),
    .ex_memread  (ctrl_q[MEMREAD_BIT]),
    .ex_valid    (valid_q),
    .ex_rt       (rt_q),
    .if_id_rs    (IF_IDrs),
    .if_id_rt    (IF_IDrt),
    .id_uses_rt  (id_uses_rt),
    .id_valid    (id_valid),
    .lu          (lu),
    .pc_write    (pc_write),
    .if_id_write (if_id_write)
  );

  // Next ID/EX contents. Priority is stall, then flush, then load-use, then a normal load.
  // A bubble zeroes the destination so the forwarder's non-zero guard ignores it.
  always_comb begin
    rs_d    = rs_q;
    rt_d    = rt_q;
    wr_d    = wr_q;
    data1_d = data1_q;
    data2_d = data2_q;
    imm_d   = imm_q;
    ctrl_d  = ctrl_q;
    valid_d = valid_q;
    if (!stall_in) begin
      if (flush || lu) begin
        rs_d    = '0;
        rt_d    = '0;
        wr_d    = '0;
        data1_d = '0;
        data2_d = '0;
        imm_d   = '0;
        ctrl_d  = CW'(BUBBLE_CTRL);
        valid_d = 1'b0;
      end else begin
        rs_d    = IF_IDrs;
        rt_d    = IF_IDrt;
        wr_d    = id_ctrl[REGDST_BIT] ? IF_IDrd : IF_IDrt;
        data1_d = id_rdata1;
        data2_d = id_rdata2;
        imm_d   = id_imm;
        ctrl_d  = id_valid ? id_ctrl : CW'(BUBBLE_CTRL);
        valid_d = id_valid;
      end
    end
  end

  // Only genuine load-use bubbles are counted.
  // Flush bubbles and stalled cycles leave the count alone.
  always_comb begin
    cnt_d = cnt_q;
    if (!stall_in && !flush && lu && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // RUN/BUBBLE tracker. BUBBLE lasts for one unstalled edge.
  always_comb begin
    state_d = state_q;
    if (!stall_in) begin
      state_d = (lu && !flush) ? ST_BUBBLE : ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_q    <= '0;
      rt_q    <= '0;
      wr_q    <= '0;
      data1_q <= '0;
      data2_q <= '0;
      imm_q   <= '0;
      ctrl_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      state_q <= ST_RUN;
    end else begin
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      wr_q    <= wr_d;
      data1_q <= data1_d;
      data2_q <= data2_d;
      imm_q   <= imm_d;
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  // The bubble clears MemRead, so a hazard cannot reappear while in BUBBLE.
  a_no_double_lu : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == ST_BUBBLE) |-> !lu);

  assign ID_EXrs    = rs_q;
  assign ID_EXrt    = rt_q;
  assign ID_EXwr    = wr_q;
  assign ID_EXdata1 = data1_q;
  assign ID_EXdata2 = data2_q;
  assign ID_EXimm   = imm_q;
  assign ID_EXctrl  = ctrl_q;
  assign ID_EXvalid = valid_q;
  assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage. Stimulus pushes expected responses into queues.
// Monitors pop them and compare against the DUT outputs.
module tb_id_ex_stage;

  localparam int CNT_W   = 6;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [7:0] CTRL_LW  = 8'hD8; // RegWrite MemRead MemtoReg ALUSrc
  localparam logic [7:0] CTRL_ADD = 8'h86; // RegWrite RegDst ALUOp=10

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall_in = 1'b0, flush = 1'b0;
  logic [4:0]  IF_IDrs = '0, IF_IDrt = '0, IF_IDrd = '0;
  logic        id_uses_rt = 1'b0, id_valid = 1'b0;
  logic [31:0] id_rdata1 = '0, id_rdata2 = '0, id_imm = '0;
  logic [7:0]  id_ctrl = '0;
  logic        pc_write, if_id_write;
  logic [4:0]  ID_EXrs, ID_EXrt, ID_EXwr;
  logic [31:0] ID_EXdata1, ID_EXdata2, ID_EXimm;
  logic [7:0]  ID_EXctrl;
  logic        ID_EXvalid;
  logic [CNT_W-1:0] bubble_cnt;

  id_ex_stage #(.DATA_W(32), .REG_AW(5), .ALUOP_W(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .flush(flush),
    .IF_IDrs(IF_IDrs), .IF_IDrt(IF_IDrt), .IF_IDrd(IF_IDrd),
    .id_uses_rt(id_uses_rt), .id_valid(id_valid),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm), .id_ctrl(id_ctrl),
    .pc_write(pc_write), .if_id_write(if_id_write),
    .ID_EXrs(ID_EXrs), .ID_EXrt(ID_EXrt), .ID_EXwr(ID_EXwr),
    .ID_EXdata1(ID_EXdata1), .ID_EXdata2(ID_EXdata2), .ID_EXimm(ID_EXimm),
    .ID_EXctrl(ID_EXctrl), .ID_EXvalid(ID_EXvalid), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs, rt, wr;
    logic [31:0] d1, d2, imm;
    logic [7:0]  ctrl;
  } ex_slot_t;

  typedef struct packed {
    ex_slot_t    ex;
    logic [31:0] cnt;
  } reg_exp_t;

  ex_slot_t model_ex;
  int       model_cnt;
  reg_exp_t reg_q[$];
  logic     comb_q[$];
  int       tests = 0;
  int       fails = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of ID inputs and predict the front-end enables and the next EX slot
  task automatic applyStimulus(input logic st, input logic fl, input logic [4:0] rs,
                               input logic [4:0] rt, input logic [4:0] rd, input logic urt,
                               input logic vld, input logic [31:0] d1, input logic [31:0] d2,
                               input logic [31:0] imm, input logic [7:0] ctrl);
    logic     hazard;
    reg_exp_t e;
    @(posedge clk);
    #2;
    stall_in = st; flush = fl; IF_IDrs = rs; IF_IDrt = rt; IF_IDrd = rd;
    id_uses_rt = urt; id_valid = vld; id_rdata1 = d1; id_rdata2 = d2; id_imm = imm;
    id_ctrl = ctrl;
    hazard = model_ex.valid && model_ex.ctrl[6] && (model_ex.rt != 0) && vld &&
             ((model_ex.rt == rs) || (urt && (model_ex.rt == rt)));
    comb_q.push_back(!(st || (hazard && !fl)));
    if (!st) begin
      if (fl || hazard) begin
        model_ex = '0;
        if (!fl) model_cnt = (model_cnt + 1 > CNT_MAX) ? CNT_MAX : model_cnt + 1;
      end else begin
        model_ex.valid = vld;
        model_ex.rs    = rs;
        model_ex.rt    = rt;
        model_ex.wr    = ctrl[2] ? rd : rt;
        model_ex.d1    = d1;
        model_ex.d2    = d2;
        model_ex.imm   = imm;
        model_ex.ctrl  = vld ? ctrl : 8'h00;
      end
    end
    e.ex  = model_ex;
    e.cnt = model_cnt;
    reg_q.push_back(e);
  endtask

  // Combinational enables, checked mid-cycle
  initial begin
    logic e;
    forever begin
      @(negedge clk);
      if (comb_q.size() != 0) begin
        e = comb_q.pop_front();
        checkOutput("pc_write", {63'd0, pc_write}, {63'd0, e});
        checkOutput("if_id_write", {63'd0, if_id_write}, {63'd0, e});
      end
    end
  end

  // Registered outputs, checked just after the edge they were predicted for
  initial begin
    reg_exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (reg_q.size() != 0) begin
        e = reg_q.pop_front();
        checkOutput("ID_EXvalid", {63'd0, ID_EXvalid}, {63'd0, e.ex.valid});
        checkOutput("ID_EXrs", {59'd0, ID_EXrs}, {59'd0, e.ex.rs});
        checkOutput("ID_EXrt", {59'd0, ID_EXrt}, {59'd0, e.ex.rt});
        checkOutput("ID_EXwr", {59'd0, ID_EXwr}, {59'd0, e.ex.wr});
        checkOutput("ID_EXdata1", {32'd0, ID_EXdata1}, {32'd0, e.ex.d1});
        checkOutput("ID_EXdata2", {32'd0, ID_EXdata2}, {32'd0, e.ex.d2});
        checkOutput("ID_EXimm", {32'd0, ID_EXimm}, {32'd0, e.ex.imm});
        checkOutput("ID_EXctrl", {56'd0, ID_EXctrl}, {56'd0, e.ex.ctrl});
        checkOutput("bubble_cnt", {58'd0, bubble_cnt}, {32'd0, e.cnt});
      end
    end
  end

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_valid"}, {63'd0, ID_EXvalid}, 64'd0);
    checkOutput({tag, "_regs"}, {49'd0, ID_EXrs, ID_EXrt, ID_EXwr}, 64'd0);
    checkOutput({tag, "_data"}, {ID_EXdata1, ID_EXdata2}, 64'd0);
    checkOutput({tag, "_imm_ctrl"}, {24'd0, ID_EXimm, ID_EXctrl}, 64'd0);
    checkOutput({tag, "_cnt"}, {58'd0, bubble_cnt}, 64'd0);
    checkOutput({tag, "_pc_write"}, {62'd0, pc_write, if_id_write}, 64'd3);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    model_ex  = '0;
    model_cnt = 0;
    #1 rst_n = 1'b0;
    #2 checkAllZero("reset");
    #20 rst_n = 1'b1;

    // Load-use on rs: freeze, bubble, count 1, then the consumer loads
    applyStimulus(0, 0, 5'd1, 5'd2, 5'd0, 1, 1, 32'h100, 32'h200, 32'h4, CTRL_LW);
    applyStimulus(0, 0, 5'd2, 5'd3, 5'd4, 1, 1, 32'h11, 32'h22, 32'h0, CTRL_ADD);
    applyStimulus(0, 0, 5'd2, 5'd3, 5'd4, 1, 1, 32'h11, 32'h22, 32'h0, CTRL_ADD);
    // rt match without rt use: no hazard
    applyStimulus(0, 0, 5'd1, 5'd2, 5'd0, 1, 1, 32'h100, 32'h200, 32'h8, CTRL_LW);
    applyStimulus(0, 0, 5'd5, 5'd2, 5'd0, 0, 1, 32'h33, 32'h44, 32'h10, 8'h88);
    // Load to $0: no hazard
    applyStimulus(0, 0, 5'd1, 5'd0, 5'd0, 1, 1, 32'h100, 32'h200, 32'hC, CTRL_LW);
    applyStimulus(0, 0, 5'd0, 5'd6, 5'd7, 1, 1, 32'h55, 32'h66, 32'h0, CTRL_ADD);
    // Load-use together with flush: bubble, no count, PC not frozen
    applyStimulus(0, 0, 5'd1, 5'd2, 5'd0, 1, 1, 32'h100, 32'h200, 32'h4, CTRL_LW);
    applyStimulus(0, 1, 5'd2, 5'd3, 5'd4, 1, 1, 32'h11, 32'h22, 32'h0, CTRL_ADD);
    // Three stalled cycles hold an add, then release
    applyStimulus(0, 0, 5'd4, 5'd5, 5'd6, 1, 1, 32'hA, 32'hB, 32'hC, CTRL_ADD);
    for (int i = 0; i < 3; i++)
      applyStimulus(1, 0, 5'd9, 5'd9, 5'd9, 1, 1, $urandom, $urandom, $urandom, CTRL_LW);
    applyStimulus(0, 0, 5'd7, 5'd8, 5'd9, 1, 1, 32'h77, 32'h88, 32'h99, CTRL_ADD);

    // Reset asserted in the middle of a stall
    applyStimulus(1, 0, 5'd1, 5'd2, 5'd3, 1, 1, 32'h1, 32'h2, 32'h3, CTRL_LW);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 checkAllZero("reset_mid_stall");
    stall_in = 1'b0; flush = 1'b0; id_valid = 1'b0; id_ctrl = '0;
    IF_IDrs = '0; IF_IDrt = '0; IF_IDrd = '0; id_uses_rt = 1'b0;
    id_rdata1 = '0; id_rdata2 = '0; id_imm = '0;
    model_ex  = '0;
    model_cnt = 0;
    #12 rst_n = 1'b1;

    // Random traffic on a small register set so hazards are frequent
    for (int i = 0; i < 400; i++)
      applyStimulus(($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 10),
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    1'($urandom), ($urandom_range(0, 9) != 0),
                    $urandom, $urandom, $urandom, 8'($urandom));

    // Drive the counter into saturation
    for (int i = 0; i < CNT_MAX + 5; i++) begin
      applyStimulus(0, 0, 5'd1, 5'd2, 5'd0, 1, 1, 32'h100, 32'h200, 32'h4, CTRL_LW);
      applyStimulus(0, 0, 5'd2, 5'd3, 5'd4, 1, 1, 32'h11, 32'h22, 32'h0, CTRL_ADD);
      applyStimulus(0, 0, 5'd2, 5'd3, 5'd4, 1, 1, 32'h11, 32'h22, 32'h0, CTRL_ADD);
    end
    @(posedge clk);
    #3;
    checkOutput("bubble_cnt_saturated", {58'd0, bubble_cnt}, 64'(CNT_MAX));
    checkOutput("scoreboard_drained", 64'(reg_q.size() + comb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
